// File: rtl/mem_line_arbiter_if.sv
// rtl/mem_line_arbiter_if.sv - upstream line request/response bus and memory line bus of mem_line_arbiter
interface mem_line_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 1024
);
    logic [NUM_PORTS-1:0]        up_req_valid;
    logic [NUM_PORTS-1:0]        up_req_ready;
    logic [NUM_PORTS-1:0]        up_req_rw;
    logic [NUM_PORTS*ADDR_W-1:0] up_req_addr;
    logic [NUM_PORTS*LINE_W-1:0] up_req_wline;
    logic [NUM_PORTS-1:0]        up_resp_valid;
    logic [LINE_W-1:0]           up_resp_rline;

    logic                        mem_req_valid;
    logic                        mem_req_ready;
    logic                        mem_req_rw;
    logic [ADDR_W-1:0]           mem_req_addr;
    logic [LINE_W-1:0]           mem_req_wline;
    logic                        mem_resp_valid;
    logic [LINE_W-1:0]           mem_resp_rline;

    // The arbiter serves the upstream ports and drives the memory side.
    modport slave (
        input  up_req_valid, up_req_rw, up_req_addr, up_req_wline,
        input  mem_req_ready, mem_resp_valid, mem_resp_rline,
        output up_req_ready, up_resp_valid, up_resp_rline,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wline
    );

    modport master (
        output up_req_valid, up_req_rw, up_req_addr, up_req_wline,
        output mem_req_ready, mem_resp_valid, mem_resp_rline,
        input  up_req_ready, up_resp_valid, up_resp_rline,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wline
    );
endinterface

// File: rtl/mem_line_arbiter.sv
// rtl/mem_line_arbiter.sv - N-port line request arbiter serialising L2 misses onto one memory line port
module mem_line_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 1024,
    parameter int ARB_MODE  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_line_arbiter_if.slave  bus,
    output logic               busy,
    output logic               err_spurious
);
    localparam int PORT_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [PORT_W-1:0]   rr_ptr_q;
    logic [PORT_W-1:0]   gnt_q;
    logic                req_rw_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [LINE_W-1:0]   req_wline_q;
    logic                mem_req_valid_q;
    logic                busy_q;
    logic                err_q;

    logic                grant_found;
    logic [PORT_W-1:0]   grant_idx;
    logic [PORT_W-1:0]   rr_next;
    logic [NUM_PORTS-1:0] ready_vec;
    logic [NUM_PORTS-1:0] resp_vec;

    // Search order: offset i from the round-robin pointer, or plain index order in fixed priority.
    function automatic logic [PORT_W-1:0] cand_port(input logic [PORT_W-1:0] base, input int offset);
        int idx;
        if (ARB_MODE == 1) begin
            idx = offset;
        end else begin
            idx = (int'(base) + offset) % NUM_PORTS;
        end
        return PORT_W'(idx);
    endfunction

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_found && bus.up_req_valid[cand_port(rr_ptr_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = cand_port(rr_ptr_q, i);
            end
        end
    end

    assign rr_next = (gnt_q == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_q + PORT_W'(1);

    always_comb begin
        ready_vec = '0;
        if (state_q == ST_IDLE && grant_found) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    // Read data is a zero-latency pass-through; only the owner of the transaction sees the strobe.
    always_comb begin
        resp_vec = '0;
        if (state_q == ST_WAIT_RESP && bus.mem_resp_valid) begin
            resp_vec[gnt_q] = 1'b1;
        end
    end

    assign bus.up_req_ready  = ready_vec;
    assign bus.up_resp_valid = resp_vec;
    assign bus.up_resp_rline = (state_q == ST_WAIT_RESP) ? bus.mem_resp_rline : '0;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_rw    = req_rw_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_req_wline = req_wline_q;
    assign busy              = busy_q;
    assign err_spurious      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            gnt_q           <= '0;
            req_rw_q        <= 1'b0;
            req_addr_q      <= '0;
            req_wline_q     <= '0;
            mem_req_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            if (bus.mem_resp_valid && state_q != ST_WAIT_RESP) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        gnt_q           <= grant_idx;
                        req_rw_q        <= bus.up_req_rw[grant_idx];
                        req_addr_q      <= bus.up_req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                        req_wline_q     <= bus.up_req_wline[int'(grant_idx)*LINE_W +: LINE_W];
                        mem_req_valid_q <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        if (req_rw_q) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                            if (ARB_MODE == 0) begin
                                rr_ptr_q <= rr_next;
                            end
                        end else begin
                            state_q <= ST_WAIT_RESP;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (bus.mem_resp_valid) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                        if (ARB_MODE == 0) begin
                            rr_ptr_q <= rr_next;
                        end
                    end
                end
                default: begin
                    mem_req_valid_q <= 1'b0;
                    busy_q          <= 1'b0;
                    state_q         <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
